// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0: shown on the instruction output whenever nothing live is presented
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a fetched instruction that arrives while the consumer is stalled.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_unload,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output logic         o_full,
    output fetch_entry_t o_entry
);

    logic         r_full;
    fetch_entry_t r_entry;

    // Flush beats load; load beats unload so a simultaneous hand-off keeps the new entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_entry <= i_entry;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_entry = r_entry;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one-outstanding memory request, output register and skid buffer.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FETCH | request outstanding at pc
//   STALL | skid full, consumer stalled, no request issued
//   DRAIN | redirect taken while a request was open; its response is
//         | discarded, address held at the old pc until the ack
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCSrc_i,
    input  logic [DATA_WIDTH-1:0] PCTarget_i,
    input  logic                  Stall_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  Valid_o,
    output logic [DATA_WIDTH-1:0] Instr_o,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] PCPlus4_o
);

    import fetch_pkg::*;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] r_drain_addr;
    logic                  r_valid;
    fetch_entry_t          r_out;

    logic                  w_ack;
    logic                  w_slot_free;
    logic                  w_take;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_unused_tgt_lsb;
    fetch_entry_t          w_fetched;
    fetch_entry_t          w_out_data;
    logic                  w_out_load;
    logic                  w_out_clear;
    logic                  w_drain_capture;
    logic                  w_skid_load;
    logic                  w_skid_unload;
    logic                  w_skid_flush;
    logic                  w_skid_full;
    fetch_entry_t          w_skid_entry;

    // Low target bits are dropped by alignment.
    assign w_unused_tgt_lsb = ^PCTarget_i[1:0];

    assign imem_req_o  = rst_n && ((r_state == FETCH) || (r_state == DRAIN));
    assign imem_addr_o = (r_state == DRAIN) ? r_drain_addr : r_pc;

    assign w_ack       = imem_ack_i && imem_req_o;
    assign w_slot_free = !r_valid || !Stall_i;
    assign w_take      = r_valid && !Stall_i;
    assign w_target    = word_align(PCTarget_i);

    assign w_fetched = '{instr: imem_rdata_i, pc: r_pc, pcplus4: r_pc + PC_STEP};

    fetch_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_flush  (w_skid_flush),
        .i_entry  (w_fetched),
        .o_full   (w_skid_full),
        .o_entry  (w_skid_entry)
    );

    // Next-state, pc and data-movement decisions; a redirect overrides everything else.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_out_load      = 1'b0;
        w_out_clear     = 1'b0;
        w_out_data      = w_fetched;
        w_skid_load     = 1'b0;
        w_skid_unload   = 1'b0;
        w_skid_flush    = 1'b0;
        w_drain_capture = 1'b0;

        if (PCSrc_i) begin
            w_out_clear  = 1'b1;
            w_skid_flush = 1'b1;
            w_pc_nxt     = w_target;
            case (r_state)
                FETCH: begin
                    if (!w_ack) begin
                        w_state_nxt     = DRAIN;
                        w_drain_capture = 1'b1;
                    end
                end
                STALL:   w_state_nxt = FETCH;
                default: w_state_nxt = r_state;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_ack) begin
                        w_pc_nxt = r_pc + PC_STEP;
                        if (w_slot_free) begin
                            w_out_load = 1'b1;
                            if (w_skid_full) begin
                                w_out_data  = w_skid_entry;
                                w_skid_load = 1'b1;
                            end
                        end else begin
                            w_skid_load = 1'b1;
                            w_state_nxt = STALL;
                        end
                    end else if (w_slot_free && w_skid_full) begin
                        w_out_load    = 1'b1;
                        w_out_data    = w_skid_entry;
                        w_skid_unload = 1'b1;
                    end else if (w_take) begin
                        w_out_clear = 1'b1;
                    end
                end
                STALL: begin
                    if (w_slot_free) begin
                        w_out_load    = 1'b1;
                        w_out_data    = w_skid_entry;
                        w_skid_unload = 1'b1;
                        w_state_nxt   = FETCH;
                    end
                end
                DRAIN: begin
                    if (w_take) w_out_clear = 1'b1;
                    if (w_ack) w_state_nxt = FETCH;
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    // State, fetch pc and the address held while draining a stale request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_drain_capture) r_drain_addr <= r_pc;
        end
    end

    // Output register; a cleared slot shows a NOP but keeps the last pc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_out   <= '{instr: NOP_INSTR, pc: '0, pcplus4: '0};
        end else if (w_out_clear) begin
            r_valid     <= 1'b0;
            r_out.instr <= NOP_INSTR;
        end else if (w_out_load) begin
            r_valid <= 1'b1;
            r_out   <= w_out_data;
        end
    end

    assign Valid_o   = r_valid;
    assign Instr_o   = r_out.instr;
    assign PC_o      = r_out.pc;
    assign PCPlus4_o = r_out.pcplus4;

endmodule
